alu_sequencer: RTL and testbench

Command-side initiator for the 4-bit combinational ALU. It accepts instruction words over a valid/ready handshake, reads operands from a private 4×4-bit register file, and drives the ALU operand and select lines. It captures the ALU result, writes it back, and returns it over a second valid/ready handshake. It sits between the instruction source (testbench or a future fetch unit) and the ALU instance.

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_seq_regfile.sv | 36 +++
 rtl/alu_sequencer.sv | 161 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and instruction field positions
// shared by the ALU sequencer and its register file.
package alu_seq_pkg;

  localparam int ADDR_W = 2;
  localparam int OP_W   = 3;
  localparam int INSTR_W = 9;

  localparam int OP_MSB  = 8;
  localparam int OP_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RA_MSB  = 3;
  localparam int RA_LSB  = 2;
  localparam int RB_MSB  = 1;
  localparam int RB_LSB  = 0;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  // Opcodes that need a trip through the external ALU.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op != OP_LDI) && (op != OP_NOP);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 4-entry register file, two async read ports,
// one sync write port, sync clear on rst.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int DW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DW-1:0]     rd_a,
  output logic [DW-1:0]     rd_b
);

  logic [DW-1:0] mem [NREGS];

  // Clear all entries on reset, otherwise write one entry on we.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rd_a = mem[ra];
  assign rd_b = mem[rb];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues instructions to an external 4-bit ALU.
// Optional result flags under `ALU_SEQ_FLAGS_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int DW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [DW-1:0]      alu_a,
  output logic [DW-1:0]      alu_b,
  output logic [2:0]         alu_s,
  input  logic [DW-1:0]      alu_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DW-1:0]      res_data,
  output logic [1:0]         res_rd
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic               res_zero,
  output logic               res_neg
`endif
);

  state_t state, state_n;

  logic [OP_W-1:0]   in_op;
  logic [ADDR_W-1:0] in_rd, in_ra, in_rb;
  logic [DW-1:0]     in_imm;
  logic [ADDR_W-1:0] rd_q;
  logic [DW-1:0]     rf_a, rf_b;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DW-1:0]     wdata;
  logic              issue_ld;
  logic              res_ld;
  logic              res_flag;
  logic [DW-1:0]     res_nxt;

  assign in_op  = in_instr[OP_MSB:OP_LSB];
  assign in_rd  = in_instr[RD_MSB:RD_LSB];
  assign in_ra  = in_instr[RA_MSB:RA_LSB];
  assign in_rb  = in_instr[RB_MSB:RB_LSB];
  assign in_imm = DW'(in_instr[IMM_MSB:IMM_LSB]);

  alu_seq_regfile #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .ra    (in_ra),
    .rb    (in_rb),
    .rd_a  (rf_a),
    .rd_b  (rf_b)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state, handshakes, RF write port and result load controls.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    we        = 1'b0;
    waddr     = rd_q;
    wdata     = alu_out;
    issue_ld  = 1'b0;
    res_ld    = 1'b0;
    res_flag  = 1'b0;
    res_nxt   = '0;
    unique case (state)
      S_IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) begin
          if (is_alu_op(in_op)) begin
            state_n  = S_ISSUE;
            issue_ld = 1'b1;
          end else begin
            state_n = S_RESP;
            res_ld  = 1'b1;
            if (in_op == OP_LDI) begin
              we       = 1'b1;
              waddr    = in_rd;
              wdata    = in_imm;
              res_nxt  = in_imm;
              res_flag = 1'b1;
            end
          end
        end
      end
      S_ISSUE: begin
        state_n  = S_RESP;
        we       = ~rst;
        res_ld   = 1'b1;
        res_nxt  = alu_out;
        res_flag = 1'b1;
      end
      S_RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // ALU operand/select drive; held outside ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_s <= '0;
      rd_q  <= '0;
    end else if (issue_ld) begin
      alu_a <= rf_a;
      alu_b <= rf_b;
      alu_s <= in_op;
      rd_q  <= in_rd;
    end
  end

  // Result registers, held stable through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data <= '0;
      res_rd   <= '0;
    end else if (res_ld) begin
      res_data <= res_nxt;
      res_rd   <= (state == S_ISSUE) ? rd_q : in_rd;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  // Zero/negative flags; forced low for NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_zero <= 1'b0;
      res_neg  <= 1'b0;
    end else if (res_ld) begin
      res_zero <= res_flag & (res_nxt == '0);
      res_neg  <= res_flag & res_nxt[DW-1];
    end
  end
`else
  logic unused_flag;
  assign unused_flag = res_flag;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed + random checks of alu_sequencer
// against a behavioural register-file/ALU model.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_instr;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_s;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [1:0] res_rd;
`ifdef ALU_SEQ_FLAGS_EN
  logic       res_zero, res_neg;
`endif

  int nvec = 0;
  int nerr = 0;
  int rf_m [4];
  int last_data;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_rd    (res_rd)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .res_zero  (res_zero),
    .res_neg   (res_neg)
`endif
  );

  // The combinational ALU the sequencer drives.
  always_comb begin
    alu_out = '0;
    case (alu_s)
      3'd0: alu_out = alu_a & alu_b;
      3'd1: alu_out = alu_a | alu_b;
      3'd2: alu_out = alu_a ^ alu_b;
      3'd3: alu_out = ~alu_a;
      3'd4: alu_out = alu_a + alu_b;
      3'd5: alu_out = alu_a - alu_b;
      default: alu_out = '0;
    endcase
  end

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model(input int op, input int a, input int b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return 15 - a;
      4: return (a + b) % 16;
      5: return (a - b + 16) % 16;
      6: return b;
      default: return 0;
    endcase
  endfunction

  task automatic run(input int op, input int rd, input int ra,
                     input int rb, input int imm, input int bp,
                     input bit early);
    int exp, lat, n;
    logic [8:0] ins;
    if (op == 6) ins = {3'(op), 2'(rd), 4'(imm)};
    else         ins = {3'(op), 2'(rd), 2'(ra), 2'(rb)};
    exp = (op == 6) ? imm : (op == 7) ? 0 : model(op, rf_m[ra], rf_m[rb]);
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid  = 1'b1;
    in_instr  = ins;
    res_ready = early;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 8) begin
      chk("busy_in_ready", int'(in_ready), 0);
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, (op < 6) ? 2 : 1);
    chk("res_data", int'(res_data), exp);
    if (op != 7) chk("res_rd", int'(res_rd), rd);
    chk("resp_in_ready", int'(in_ready), 0);
`ifdef ALU_SEQ_FLAGS_EN
    chk("res_zero", int'(res_zero), (op != 7 && exp == 0) ? 1 : 0);
    chk("res_neg", int'(res_neg), (op != 7 && exp >= 8) ? 1 : 0);
`endif
    last_data = int'(res_data);
    if (!early) begin
      for (int k = 0; k < bp; k++) begin
        @(posedge clk); #1;
        chk("bp_valid", int'(res_valid), 1);
        chk("bp_data", int'(res_data), exp);
        chk("bp_in_ready", int'(in_ready), 0);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("done_valid", int'(res_valid), 0);
    chk("idle_ready", int'(in_ready), 1);
    if (op != 7) rf_m[rd] = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) rf_m[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_alu_a", int'(alu_a), 0);
    chk("rst_alu_s", int'(alu_s), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", int'(in_ready), 1);

    // Directed sequence with literal expectations.
    run(6, 0, 0, 0, 4'b0110, 0, 0);
    run(6, 1, 0, 0, 4'b0011, 0, 0);
    run(0, 2, 0, 1, 0, 0, 0); chk("seq_and", last_data, 4'b0010);
    run(1, 2, 0, 1, 0, 0, 0); chk("seq_or",  last_data, 4'b0111);
    run(2, 2, 0, 1, 0, 0, 0); chk("seq_xor", last_data, 4'b0101);
    run(3, 3, 0, 1, 0, 0, 0); chk("seq_not", last_data, 4'b1001);
    run(4, 2, 0, 1, 0, 0, 0); chk("seq_add", last_data, 4'b1001);
    run(5, 2, 0, 1, 0, 5, 0); chk("seq_sub", last_data, 4'b0011);

    // Early res_ready, aliasing and wrap.
    run(6, 3, 0, 0, 4'b1111, 0, 1);
    run(6, 2, 0, 0, 4'b0001, 0, 1);
    run(4, 3, 3, 2, 0, 0, 0); chk("wrap_add", last_data, 0);
    run(4, 0, 0, 0, 0, 0, 0); chk("alias_r0", last_data, 4'b1100);

    // NOP leaves registers alone.
    run(7, 1, 0, 0, 0, 2, 0); chk("nop_data", last_data, 0);
    run(1, 2, 1, 1, 0, 0, 0); chk("nop_rf_kept", last_data, 4'b0011);

    // Reset pulsed while in ISSUE.
    in_valid = 1'b1;
    in_instr = {3'd4, 2'd3, 2'd0, 2'd1};
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", int'(res_valid), 0);
    chk("midrst_alu_a", int'(alu_a), 0);
    rst = 1'b0;
    #1;
    chk("midrst_ready", int'(in_ready), 1);
    chk("midrst_valid2", int'(res_valid), 0);
    for (int i = 0; i < 4; i++) rf_m[i] = 0;
    run(1, 0, 1, 3, 0, 0, 0); chk("rf_cleared", last_data, 0);
    run(3, 1, 2, 0, 0, 0, 0); chk("rf_cleared_not", last_data, 15);

    // Randomized traffic against the model.
    for (int t = 0; t < 150; t++) begin
      run($urandom_range(0, 7), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 15), $urandom_range(0, 3),
          1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
